// File: rtl/sigmoid_pwq_eval.sv
// Four-stage piecewise-quadratic sigmoid for signed Q8.24 inputs, producing Q8.24 in [0, 1.0].
// Per-segment coefficients come from three small lookup modules defined ahead of the top.

module coef_term1 (
    input  logic        [2:0]  idx,
    output logic signed [31:0] c
);
    always_comb begin
        case (idx)
            3'd0:       c = 32'sd8388608;
            3'd1:       c = 32'sd8190637;
            3'd2:       c = 32'sd9388530;
            3'd3:       c = 32'sd11764184;
            3'd4, 3'd5: c = 32'sd14525714;
            default:    c = 32'sd0;
        endcase
    end
endmodule

module coef_term2 (
    input  logic        [2:0]  idx,
    output logic signed [31:0] c
);
    always_comb begin
        case (idx)
            3'd0:       c = 32'sd4194304;
            3'd1:       c = 32'sd4857004;
            3'd2:       c = 32'sd3687632;
            3'd3:       c = 32'sd2090441;
            3'd4, 3'd5: c = 32'sd725614;
            default:    c = 32'sd0;
        endcase
    end
endmodule

module coef_term3 (
    input  logic        [2:0]  idx,
    output logic signed [31:0] c
);
    always_comb begin
        case (idx)
            3'd0:       c = 32'sd0;
            3'd1:       c = -32'sd781818;
            3'd2:       c = -32'sd496606;
            3'd3:       c = -32'sd228170;
            3'd4, 3'd5: c = -32'sd59559;
            default:    c = 32'sd0;
        endcase
    end
endmodule

module sigmoid_pwq_eval #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_y
);
    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC;

    logic adv;
    logic v_s1, v_s2, v_s3;

    logic        neg_in;
    logic [31:0] ax_in;
    logic [2:0]  idx_in;

    logic        s1_neg;
    logic [31:0] s1_ax;
    logic [2:0]  s1_idx;

    logic signed [31:0] c1, c2, c3;
    logic signed [31:0] s2_c1, s2_c2, s2_c3;
    logic        [31:0] s2_sq, s2_ax;
    logic               s2_neg;
    logic        [2:0]  s2_idx;

    logic signed [31:0] s3_c1, s3_p2, s3_p3;
    logic               s3_neg;
    logic        [2:0]  s3_idx;

    logic signed [31:0] f_sum, f, y;

    // Every stage advances together; a full output register blocks the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // The most negative input has no positive twin, so its magnitude saturates.
    always_comb begin
        neg_in = in_x[DWIDTH-1];
        if (in_x == 32'h8000_0000)
            ax_in = 32'h7FFF_FFFF;
        else if (neg_in)
            ax_in = -in_x;
        else
            ax_in = in_x;
        if (ax_in[DWIDTH-1:FRAC] >= 8'd6)
            idx_in = 3'd6;
        else
            idx_in = ax_in[FRAC+2:FRAC];
    end

    coef_term1 u_coef1 (.idx(s1_idx), .c(c1));
    coef_term2 u_coef2 (.idx(s1_idx), .c(c2));
    coef_term3 u_coef3 (.idx(s1_idx), .c(c3));

    // Segment 6 is pinned to 1.0, which also hides any wrap of the square.
    always_comb begin
        f_sum = s3_c1 + s3_p2 + s3_p3;
        if (s3_idx == 3'd6)
            f = ONE;
        else if (f_sum < 0)
            f = 32'sd0;
        else if (f_sum > ONE)
            f = ONE;
        else
            f = f_sum;
        y = s3_neg ? (ONE - f) : f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1      <= 1'b0;
            v_s2      <= 1'b0;
            v_s3      <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            s1_neg    <= 1'b0;
            s1_ax     <= '0;
            s1_idx    <= '0;
            s2_c1     <= '0;
            s2_c2     <= '0;
            s2_c3     <= '0;
            s2_sq     <= '0;
            s2_ax     <= '0;
            s2_neg    <= 1'b0;
            s2_idx    <= '0;
            s3_c1     <= '0;
            s3_p2     <= '0;
            s3_p3     <= '0;
            s3_neg    <= 1'b0;
            s3_idx    <= '0;
        end else if (adv) begin
            v_s1   <= in_valid;
            s1_neg <= neg_in;
            s1_ax  <= ax_in;
            s1_idx <= idx_in;

            v_s2   <= v_s1;
            s2_c1  <= c1;
            s2_c2  <= c2;
            s2_c3  <= c3;
            s2_sq  <= 32'((64'(s1_ax) * 64'(s1_ax)) >> FRAC);
            s2_ax  <= s1_ax;
            s2_neg <= s1_neg;
            s2_idx <= s1_idx;

            v_s3   <= v_s2;
            s3_c1  <= s2_c1;
            s3_p2  <= 32'((64'(s2_c2) * 64'($signed(s2_ax))) >>> FRAC);
            s3_p3  <= 32'((64'(s2_c3) * 64'($signed(s2_sq))) >>> FRAC);
            s3_neg <= s2_neg;
            s3_idx <= s2_idx;

            out_valid <= v_s3;
            if (v_s3)
                out_y <= y;
        end
    end
endmodule

// File: tb/tb_sigmoid_pwq_eval.sv
// Bench for sigmoid_pwq_eval: directed corner values, randomized streams under backpressure,
// and an asynchronous reset with samples in flight, checked against a real-valued segment model.

module tb_sigmoid_pwq_eval;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;

    int n_assert = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;
    bit sb_en    = 0;
    bit hold_chk = 0;
    logic [31:0] held_y;
    logic [31:0] exp_q[$];

    // Segment coefficient tables (Q8.24); segments 4 and 5 share one entry.
    int c1_t[5] = '{8388608, 8190637, 9388530, 11764184, 14525714};
    int c2_t[5] = '{4194304, 4857004, 3687632, 2090441, 725614};
    int c3_t[5] = '{0, -781818, -496606, -228170, -59559};

    sigmoid_pwq_eval dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] x);
        longint sx, ax, idx, seg, sq, p2, p3, f, one;
        one = 64'sd1 << 24;
        sx  = longint'($signed(x));
        ax  = (sx < 0) ? -sx : sx;
        if (ax > 64'sh7FFF_FFFF) ax = 64'sh7FFF_FFFF;
        idx = ax / one;
        if (idx > 6) idx = 6;
        if (idx == 6) begin
            f = one;
        end else begin
            seg = (idx == 5) ? 4 : idx;
            sq  = (ax * ax) / one;
            p2  = (longint'(c2_t[seg]) * ax) >>> 24;
            p3  = (longint'(c3_t[seg]) * sq) >>> 24;
            f   = longint'(c1_t[seg]) + p2 + p3;
            if (f < 0) f = 0;
            if (f > one) f = one;
        end
        if (sx < 0) f = one - f;
        return 32'(f);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] rand_x();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1, 2:    return 32'($urandom_range(0, 32'h0E00_0000)) - 32'h0700_0000;
            default: return 32'($urandom_range(0, 32'h0300_0000)) - 32'h0180_0000;
        endcase
    endfunction

    // Scoreboard: predicts on input transfer, compares on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (hold_chk) chk("hold_stable", out_y, held_y);
            hold_chk = out_valid && !out_ready;
            held_y   = out_y;
            if (sb_en && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("extra_output", out_y, 32'hxxxx_xxxx);
                else chk("stream", out_y, exp_q.pop_front());
            end
            if (sb_en && in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(in_x));
            end
        end
    end

    task automatic send_check(input logic [31:0] x, input logic [31:0] expv, input string tag);
        int lat;
        @(posedge clk); #1;
        in_x = x;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk(tag, out_y, expv);
    endtask

    task automatic send(input logic [31:0] x);
        bit acc;
        int n;
        in_x = x;
        in_valid = 1;
        n = 0;
        acc = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_x = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_y", out_y, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        send_check(32'h0000_0000, 32'h0080_0000, "zero");
        send_check(32'h0080_0000, 32'h00A0_0000, "pos_half");
        send_check(32'hFF80_0000, 32'h0060_0000, "neg_half");
        // 1.0 uses segment 1: c1+c2+c3 of that segment, exactly.
        send_check(32'h0100_0000, 32'h00BB_295F, "seg1_edge");
        send_check(32'h0800_0000, 32'h0100_0000, "pos_eight");
        send_check(32'hF800_0000, 32'h0000_0000, "neg_eight");
        send_check(32'h8000_0000, 32'h0000_0000, "most_neg");
        send_check(32'h0600_0000, 32'h0100_0000, "seg6_edge");
        send_check(32'h05FF_FFFF, model(32'h05FF_FFFF), "seg5_top");
        send_check(32'hFF00_0000, model(32'hFF00_0000), "neg_one");

        @(posedge clk); #1;
        sb_en = 1;
        for (int i = 0; i < 8; i++) send(rand_x());

        fork
            begin
                out_ready = 0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join_none
        for (int i = 0; i < 8; i++) send(rand_x());

        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join_none
        for (int i = 0; i < 24; i++) send(rand_x());

        repeat (50) @(posedge clk);
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(n_out), 32'(n_in));

        for (int i = 0; i < 3; i++) send(rand_x());
        #3 rst_n = 0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_valids", {28'd0, dut.v_s1, dut.v_s2, dut.v_s3, out_valid}, 32'd0);
        chk("async_rst_out_y", out_y, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
